sub_shift_rows: RTL
===================

// Module: sub_shift_rows
// PURPOSE
//  Iterative AES SubBytes + ShiftRows stage; sits directly upstream of mix_columns in the round datapath.
//  - Accepts a 128-bit state and substitutes BYTES_PER_CYCLE bytes per cycle through shared forward S-boxes.
//  - Applies ShiftRows on the registered result and presents it through a valid/ready handshake.
//  - Its output feeds mix_columns_in, or the final AddRoundKey in the last round.
// PARAMETERS
//  BYTES_PER_CYCLE  4  S-box lanes; legal 1,2,4,8,16; N = 16/BYTES_PER_CYCLE substitution cycles
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    in_state valid
//  in_ready   out  1    stage can accept a state
//  in_state   in   128  AES state; byte b=4c+r (row r, col c) at [127-8b -: 8]
//  out_valid  out  1    out_state valid
//  out_ready  in   1    consumer accepts out_state
//  out_state  out  128  ShiftRows(SubBytes(in_state)), same byte layout
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge):
//    - state IDLE, in_ready=1, out_valid=0, out_state=0, byte counter=0.
//    - Reset mid-operation discards the in-flight state; no partial result is ever presented.
//  - FSM IDLE:
//    - in_ready=1; in_valid=1 captures in_state into the work register; go to SUB with cnt=0.
//  - FSM SUB:
//    - in_ready=0; each cycle, bytes [cnt*BPC .. cnt*BPC+BPC-1] of the work register are replaced by sbox(byte).
//    - cnt increments; at cnt==N-1 the last group is written and the state goes to HOLD.
//  - FSM HOLD:
//    - out_valid=1; out_state = ShiftRows(work): out byte(r,c) = work byte(r,(c+r) mod 4).
//    - out_state is registered and stable while out_valid=1 && out_ready=0.
//    - out_ready=1 -> out_valid falls next cycle; go to IDLE.
//  - Latency: accept at edge E; out_valid=1 after edge E+N (BPC=4 -> 4 cycles, BPC=16 -> 1 cycle).
//  - Throughput: one state per N+2 cycles when out_ready is held high. in_ready is never 1 outside IDLE; no overlap.
//  - in_valid while not IDLE is ignored; the upstream must hold until in_ready.
//  - S-box is the FIPS-197 forward table (combinational case ROM); the same function is instanced per lane.
//  - out_state keeps its last value after handshake until the next HOLD entry.
// CONFIGURATION
//  SUB_SHIFT_STALL_CNT_EN defined:
//   - Adds port stall_cnt (out, 16): counts cycles with out_valid=1 && out_ready=0.
//   - Saturates at 16'hFFFF; cleared only by rst.
//  SUB_SHIFT_STALL_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 in_state=193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1 -> out_state=d4bf5d30e0b452aeb84111f11e2798e5 (FIPS-197 App.B rnd1).
//  2 in_state=0, BPC=4 -> out_valid exactly 4 cycles after accept, out_state=6363..63 (all 16 bytes 0x63).
//  3 out_ready=0 for 10 cycles in HOLD -> out_state stable, in_ready=0, new in_valid ignored; stall_cnt=10 when macro defined.
//  4 rst pulsed during SUB (cnt=2) -> next cycle in_ready=1, out_valid=0, out_state=0; next accepted state correct.
//  5 back-to-back in_valid=1, out_ready=1 -> accepts every N+2 cycles; 3 App.B states out in order.
//  6 sweep BPC in {1,2,8,16} with test 1 vector -> identical out_state, latency 16/8/2/1.

Source files
------------

// File: rtl/sub_shift_rows.sv
// sub_shift_rows: iterative AES SubBytes + ShiftRows round stage.
// Substitutes BYTES_PER_CYCLE bytes of the captured state per cycle through
// shared forward S-box lanes, then presents ShiftRows of the result on a
// valid/ready output. Feeds mix_columns (or the final AddRoundKey).
// Optional feature: define SUB_SHIFT_STALL_CNT_EN to add the 16-bit
// saturating stall_cnt output (cycles with out_valid=1 and out_ready=0).
// Byte layout: byte b = 4c+r (row r, column c) lives at [127-8b -: 8].
module sub_shift_rows #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
`ifdef SUB_SHIFT_STALL_CNT_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);

  localparam int         N        = 16 / BYTES_PER_CYCLE;
  localparam int         LOG_BPC  = $clog2(BYTES_PER_CYCLE);
  localparam logic [3:0] CNT_LAST = 4'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_HOLD
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       cnt_q;
  logic [3:0]       cnt_d;
  logic [3:0]       grp_base;
  // Packed with ascending byte index so work_p0[b] is AES byte b.
  logic [0:15][7:0] work_p0;
  logic [0:15][7:0] work_sub;

  // FIPS-197 forward S-box as a combinational case ROM.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    s = 8'h00;
    case (a)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4).
  function automatic logic [127:0] shift_rows(input logic [0:15][7:0] s);
    logic [0:15][7:0] r;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[4'(4 * c + w)] = s[4'(4 * ((c + w) % 4) + w)];
      end
    end
    return r;
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Replace the current byte group of the work register through the S-box lanes.
  always_comb begin
    work_sub = work_p0;
    grp_base = cnt_q << LOG_BPC;
    for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
      work_sub[grp_base + 4'(l)] = sbox(work_p0[grp_base + 4'(l)]);
    end
  end

  // Next-state, counter and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = S_SUB;
          cnt_d   = '0;
        end
      end
      S_SUB: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state register; reset abandons any in-flight state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // p0: work register captures the input, then absorbs one substituted group per cycle.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && in_valid) begin
      work_p0 <= in_state;
    end else if (state_q == S_SUB) begin
      work_p0 <= work_sub;
    end
  end

  // Output register loads ShiftRows of the final group together with the HOLD entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= '0;
    end else if (state_q == S_SUB && cnt_q == CNT_LAST) begin
      out_state <= shift_rows(work_sub);
    end
  end

`ifdef SUB_SHIFT_STALL_CNT_EN
  // Count cycles where a result waits on the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt <= sat_inc16(stall_cnt);
    end
  end
`endif

endmodule
